// File: rtl/guess_ctrl_if.sv
// guess_ctrl_if: bundle between the search controller and its environment.
// master = controller (drives guess/status), slave = comparator/host side.
// SEQ_STEP_EN adds the step input used for one-probe-per-keypress mode.
interface guess_ctrl_if #(
    parameter int WIDTH = 3
);
    localparam int CW = $clog2(WIDTH + 2);

    logic             start;
`ifdef SEQ_STEP_EN
    logic             step;
`endif
    logic             xgy;
    logic             xsy;
    logic             xey;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    tries;

    modport master (
        input  start,
`ifdef SEQ_STEP_EN
        input  step,
`endif
        input  xgy, xsy, xey,
        output guess, busy, done, err, result, tries
    );

    modport slave (
        output start,
`ifdef SEQ_STEP_EN
        output step,
`endif
        output xgy, xsy, xey,
        input  guess, busy, done, err, result, tries
    );
endinterface

// File: rtl/guess_ctrl.sv
// guess_ctrl: successive-approximation search around a magnitude comparator.
// Ports: clk, rst (async, active-high), bus (guess_ctrl_if.master):
//   start, [step], xgy/xsy/xey in; guess, busy, done, err, result, tries out.
// Macro SEQ_STEP_EN: probes advance only on cycles where step=1.
module guess_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    guess_ctrl_if.master  bus
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] MID  = MAXV >> 1;

    typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] guess_q, lo_q, hi_q, result_q;
    logic [WIDTH-1:0] lo_d, hi_d, guess_d;
    logic [WIDTH:0]   sum_d;
    logic [CW-1:0]    tries_q, tries_d;
    logic             busy_q, done_q, err_q;
    logic             adv;
    logic [2:0]       flags;

    assign flags = {bus.xgy, bus.xsy, bus.xey};

`ifdef SEQ_STEP_EN
    assign adv = bus.step;
`else
    assign adv = 1'b1;
`endif

    // Narrowed range and next midpoint; sum kept one bit wider to avoid wrap.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (bus.xgy) lo_d = guess_q + WIDTH'(1);
        if (bus.xsy) hi_d = guess_q - WIDTH'(1);
        sum_d   = {1'b0, lo_d} + {1'b0, hi_d};
        guess_d = WIDTH'(sum_d >> 1);
        tries_d = (tries_q == '1) ? tries_q : tries_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            lo_q     <= '0;
            hi_q     <= MAXV;
            result_q <= '0;
            tries_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        lo_q    <= '0;
                        hi_q    <= MAXV;
                        guess_q <= MID;
                        tries_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= PROBE;
                    end
                end
                PROBE: begin
                    if (adv) begin
                        tries_q <= tries_d;
                        case (flags)
                            3'b001: begin
                                result_q <= guess_q;
                                done_q   <= 1'b1;
                                busy_q   <= 1'b0;
                                state_q  <= DONE;
                            end
                            3'b100, 3'b010: begin
                                // Range exhausted: x lies outside [lo, hi].
                                if ((bus.xgy && guess_q == hi_q) ||
                                    (bus.xsy && guess_q == lo_q)) begin
                                    err_q   <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ERR;
                                end else begin
                                    lo_q    <= lo_d;
                                    hi_q    <= hi_d;
                                    guess_q <= guess_d;
                                end
                            end
                            default: begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ERR;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.tries  = tries_q;
endmodule

// File: tb/tb_guess_ctrl.sv
// tb_guess_ctrl: directed bench for guess_ctrl with a behavioural comparator.
// Flags can be overridden to inject faulty comparator outputs.
module tb_guess_ctrl;
    logic       clk;
    logic       rst;
    logic [2:0] x;
    logic       fen;
    logic [2:0] fv;
    int         errors;
    int         checks;

    guess_ctrl_if #(.WIDTH(3)) bus ();

    guess_ctrl #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.xgy = fen ? fv[2] : (x > bus.guess);
    assign bus.xsy = fen ? fv[1] : (x < bus.guess);
    assign bus.xey = fen ? fv[0] : (x == bus.guess);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic search(input int xv, input int n, input int gs[4],
                          input int res);
        x = 3'(xv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_clr", int'(bus.err), 0);
        chk("done_clr", int'(bus.done), 0);
        for (int i = 0; i < n; i++) begin
            chk("guess", int'(bus.guess), gs[i]);
            chk("tries_run", int'(bus.tries), i);
            chk("busy_run", int'(bus.busy), 1);
            tick();
        end
        chk("done", int'(bus.done), 1);
        chk("busy_end", int'(bus.busy), 0);
        chk("result", int'(bus.result), res);
        chk("tries_end", int'(bus.tries), n);
        chk("err_end", int'(bus.err), 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        x         = 3'd0;
        fen       = 1'b0;
        fv        = 3'b000;
        bus.start = 1'b0;
`ifdef SEQ_STEP_EN
        bus.step  = 1'b1;
`endif
        #3;
        chk("rst_guess", int'(bus.guess), 0);
        chk("rst_tries", int'(bus.tries), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_result", int'(bus.result), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_hold", int'(bus.busy), 0);

        search(5, 2, '{3, 5, 0, 0}, 5);
        search(7, 4, '{3, 5, 6, 7}, 7);
        search(0, 3, '{3, 1, 0, 0}, 0);

        // Comparator giving no flag on the first probe.
        fen = 1'b1;
        fv  = 3'b000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("e0_guess", int'(bus.guess), 3);
        tick();
        chk("e0_err", int'(bus.err), 1);
        chk("e0_busy", int'(bus.busy), 0);
        chk("e0_tries", int'(bus.tries), 1);

        // Two flags at once.
        fv = 3'b011;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("e1_err_clr", int'(bus.err), 0);
        tick();
        chk("e1_err", int'(bus.err), 1);
        chk("e1_busy", int'(bus.busy), 0);
        chk("e1_tries", int'(bus.tries), 1);

        fen = 1'b0;
        search(4, 3, '{3, 5, 4, 0}, 4);

        // Stuck x>guess: walks up then exhausts at hi.
        fen = 1'b1;
        fv  = 3'b100;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stk_guess", int'(bus.guess), (i == 0) ? 3 : (i == 1) ? 5 :
                                              (i == 2) ? 6 : 7);
            tick();
        end
        chk("stk_err", int'(bus.err), 1);
        chk("stk_tries", int'(bus.tries), 4);
        chk("stk_done", int'(bus.done), 0);
        tick();
        chk("stk_hold_g", int'(bus.guess), 7);
        chk("stk_hold_e", int'(bus.err), 1);
        fen = 1'b0;

        // Asynchronous reset mid-search.
        x = 3'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ar_pre_g", int'(bus.guess), 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_guess", int'(bus.guess), 0);
        chk("ar_tries", int'(bus.tries), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_done", int'(bus.done), 0);
        chk("ar_err", int'(bus.err), 0);
        #1 rst = 1'b0;
        tick();
        tick();
        chk("ar_idle_g", int'(bus.guess), 0);
        chk("ar_idle_b", int'(bus.busy), 0);

        // start held while busy must not restart.
        bus.start = 1'b1;
        tick();
        chk("sb_g0", int'(bus.guess), 3);
        tick();
        chk("sb_g1", int'(bus.guess), 5);
        chk("sb_t1", int'(bus.tries), 1);
        bus.start = 1'b0;
        tick();
        chk("sb_g2", int'(bus.guess), 6);
        chk("sb_t2", int'(bus.tries), 2);
        tick();
        chk("sb_done", int'(bus.done), 1);
        chk("sb_res", int'(bus.result), 6);
        chk("sb_tries", int'(bus.tries), 3);

`ifdef SEQ_STEP_EN
        bus.step  = 1'b0;
        x         = 3'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("st_hold_g", int'(bus.guess), 3);
        chk("st_hold_t", int'(bus.tries), 0);
        chk("st_hold_b", int'(bus.busy), 1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("st_g1", int'(bus.guess), 1);
        chk("st_t1", int'(bus.tries), 1);
        tick();
        chk("st_g1_hold", int'(bus.guess), 1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("st_g2", int'(bus.guess), 2);
        chk("st_t2", int'(bus.tries), 2);
        chk("st_busy", int'(bus.busy), 1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("st_done", int'(bus.done), 1);
        chk("st_res", int'(bus.result), 2);
        chk("st_tries", int'(bus.tries), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
